// File: rtl/ppu_vram_writer.sv
// CPU-side VRAM access port: PPUADDR/PPUDATA/PPUSTATUS decode, 14-bit v/t address
// with two-write latch, and a single pending VRAM access held until the arbiter grants.
module ppu_vram_writer #(
    parameter int ADDR_W  = 14,
    parameter int INC_BIG = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_data_out,
    input  logic        ppuctrl_inc,
    output logic        vram_req,
    input  logic        vram_grant,
    output logic [15:0] VRAM_addr,
    output logic        VRAM_WE,
    output logic [7:0]  VRAM_data_out,
    input  logic [7:0]  VRAM_data_in,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, PEND_WR, PEND_RD, RD_WAIT} state_t;

    state_t            state, state_nx;
    logic              w;
    logic [ADDR_W-1:0] t, v, inc;
    logic [7:0]        wr_buf, rd_buf;
    logic              wr_stb, rd_stb, idle, v_step;

    // a simultaneous write wins; the read strobe is dropped
    assign wr_stb = cpu_we;
    assign rd_stb = cpu_re & ~cpu_we;
    assign idle   = (state == IDLE);
    assign inc    = ppuctrl_inc ? ADDR_W'(INC_BIG) : ADDR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        vram_req = 1'b0;
        VRAM_WE  = 1'b0;
        v_step   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_stb && cpu_addr == 3'd7)      state_nx = PEND_WR;
                else if (rd_stb && cpu_addr == 3'd7) state_nx = PEND_RD;
            end
            PEND_WR: begin
                vram_req = 1'b1;
                VRAM_WE  = vram_grant;
                if (vram_grant) begin
                    v_step   = 1'b1;
                    state_nx = IDLE;
                end
            end
            PEND_RD: begin
                vram_req = 1'b1;
                if (vram_grant) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                v_step   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w      <= 1'b0;
            t      <= '0;
            v      <= '0;
            wr_buf <= 8'h00;
            rd_buf <= 8'h00;
        end else begin
            if (rd_stb && cpu_addr == 3'd2) w <= 1'b0;
            if (idle && wr_stb && cpu_addr == 3'd6) begin
                if (!w) begin
                    t[ADDR_W-1:8] <= cpu_data_in[ADDR_W-9:0];
                    w             <= 1'b1;
                end else begin
                    t[7:0] <= cpu_data_in;
                    v      <= {t[ADDR_W-1:8], cpu_data_in};
                    w      <= 1'b0;
                end
            end
            if (idle && wr_stb && cpu_addr == 3'd7) wr_buf <= cpu_data_in;
            if (state == RD_WAIT) rd_buf <= VRAM_data_in;
            // v_step only fires outside IDLE, so it never collides with a PPUADDR load
            if (v_step) v <= v + inc;
        end
    end

    assign VRAM_addr     = {{(16-ADDR_W){1'b0}}, v};
    assign VRAM_data_out = wr_buf;
    assign busy          = !idle;
    assign cpu_data_out  = (cpu_addr == 3'd7) ? rd_buf : 8'h00;

endmodule

// File: tb/tb_ppu_vram_writer.sv
// Scoreboard bench for ppu_vram_writer: VRAM writes and buffered reads are predicted
// by a small address/latch model and checked when the DUT produces them.
module tb_ppu_vram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_we, cpu_re;
    logic [7:0]  cpu_data_out;
    logic        ppuctrl_inc;
    logic        vram_req, vram_grant;
    logic [15:0] VRAM_addr;
    logic        VRAM_WE;
    logic [7:0]  VRAM_data_out;
    logic [7:0]  vram_q;
    logic        busy;

    ppu_vram_writer #(.ADDR_W(14), .INC_BIG(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_data_out(cpu_data_out),
        .ppuctrl_inc(ppuctrl_inc),
        .vram_req(vram_req), .vram_grant(vram_grant),
        .VRAM_addr(VRAM_addr), .VRAM_WE(VRAM_WE),
        .VRAM_data_out(VRAM_data_out), .VRAM_data_in(vram_q),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0;

    logic [7:0]  mem [0:16383];
    logic [23:0] wq [$];
    logic [7:0]  rq [$];

    logic        w_m;
    logic [13:0] t_m, v_m;
    logic [7:0]  rd_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // VRAM with one-cycle read latency
    always @(posedge clk) begin
        if (VRAM_WE) mem[VRAM_addr[13:0]] <= VRAM_data_out;
        vram_q <= mem[VRAM_addr[13:0]];
    end

    always @(negedge clk) begin
        if (reset && VRAM_WE) begin
            we_cnt++;
            if (wq.size() == 0) chk("spurious_we", 1, 0);
            else chk("vram_wr", {8'h00, VRAM_addr, VRAM_data_out}, {8'h00, wq.pop_front()});
        end
    end

    function automatic logic [13:0] inc_m();
        return ppuctrl_inc ? 14'd32 : 14'd1;
    endfunction

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_v(input string tag);
        chk(tag, {16'h0, VRAM_addr}, {18'h0, v_m});
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d, input bit hold, input bit also_re);
        if (a == 3'd6) begin
            if (!w_m) begin
                t_m[13:8] = d[5:0];
                w_m = 1;
            end else begin
                t_m[7:0] = d;
                v_m = t_m;
                w_m = 0;
            end
        end
        if (a == 3'd7) begin
            wq.push_back({2'b00, v_m, d});
            v_m = v_m + inc_m();
        end
        cpu_addr = a; cpu_data_in = d; cpu_we = 1; cpu_re = also_re;
        @(posedge clk); #1;
        cpu_we = 0; cpu_re = 0;
        if (a == 3'd7 && !hold) wait_idle();
    endtask

    task automatic reg_rd(input logic [2:0] a, input bit hold);
        if (a == 3'd2) w_m = 0;
        if (a == 3'd7) begin
            rq.push_back(rd_m);
            rd_m = mem[v_m];
            v_m = v_m + inc_m();
        end
        cpu_addr = a; cpu_re = 1;
        #1;
        if (a == 3'd7) chk("rd_data", {24'h0, cpu_data_out}, {24'h0, rq.pop_front()});
        @(posedge clk); #1;
        cpu_re = 0;
        if (a == 3'd7 && !hold) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        reset = 0; cpu_addr = 3'd7; cpu_data_in = 0; cpu_we = 0; cpu_re = 0;
        ppuctrl_inc = 0; vram_grant = 1;
        w_m = 0; t_m = 0; v_m = 0; rd_m = 0;
        #12;
        chk("rst_outs", {VRAM_addr, cpu_data_out, 5'b0, vram_req, VRAM_WE, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1;

        // address latch, then single write and +1 increment
        reg_wr(3'd6, 8'h21, 0, 0);
        reg_wr(3'd6, 8'h08, 0, 0);
        chk_v("v_2108");
        snap = we_cnt;
        reg_wr(3'd7, 8'h5A, 0, 0);
        chk_v("v_2109");
        chk("we_once", we_cnt, snap + 1);

        // +32 increment with wrap past 0x3FFF
        ppuctrl_inc = 1;
        reg_wr(3'd6, 8'h3F, 0, 0);
        reg_wr(3'd6, 8'hF0, 0, 0);
        reg_wr(3'd7, 8'hC3, 0, 0);
        chk_v("v_wrap");
        ppuctrl_inc = 0;

        // buffered reads
        reg_wr(3'd6, 8'h20, 0, 0);
        reg_wr(3'd6, 8'h00, 0, 0);
        reg_wr(3'd7, 8'h11, 0, 0);
        reg_wr(3'd7, 8'h22, 0, 0);
        reg_wr(3'd7, 8'h33, 0, 0);
        reg_wr(3'd6, 8'h20, 0, 0);
        reg_wr(3'd6, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) reg_rd(3'd7, 0);
        chk_v("v_2003");

        // latch reset through PPUSTATUS read
        reg_wr(3'd6, 8'h3F, 0, 0);
        reg_rd(3'd2, 0);
        reg_wr(3'd6, 8'h23, 0, 0);
        reg_wr(3'd6, 8'h45, 0, 0);
        chk_v("v_2345");

        // held without grant; second write while busy is dropped
        vram_grant = 0;
        snap = we_cnt;
        reg_wr(3'd7, 8'hA5, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold", {29'h0, vram_req, busy, VRAM_WE}, 32'b110);
            @(posedge clk); #1;
            cpu_addr = 3'd7;
            cpu_data_in = (i == 4) ? 8'h77 : 8'h00;
            cpu_we = (i == 4);
        end
        cpu_we = 0;
        vram_grant = 1;
        wait_idle();
        chk("we_after_hold", we_cnt, snap + 1);
        chk_v("v_2346");

        // reset in RD_WAIT discards the read
        reg_rd(3'd7, 1);
        @(posedge clk); #1;
        chk("in_rd_wait", {31'h0, busy}, 1);
        reset = 0;
        #1;
        chk("rst_mid", {VRAM_addr, cpu_data_out, 5'b0, vram_req, VRAM_WE, busy}, 32'h0);
        w_m = 0; t_m = 0; v_m = 0; rd_m = 0;
        @(posedge clk); #1;
        reset = 1;
        snap = we_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("no_we_after_rst", we_cnt, snap);

        // simultaneous write and read strobe: write path only
        reg_wr(3'd7, 8'h99, 0, 1);
        chk("we_simul", we_cnt, snap + 1);
        chk_v("v_0001");
        reg_rd(3'd7, 0);
        chk("wq_empty", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
